bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 28 ++
 rtl/bus_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_bus_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared constants for the two-master / two-slave bus arbiter.
package bus_pkg;

    localparam int unsigned BUS_WIDTH_DEF = 8;
    localparam int unsigned ADDR_W        = 8;
    localparam logic [ADDR_W-1:0] S1_ADDR_DEF = 8'h02;
    localparam logic [ADDR_W-1:0] S2_ADDR_DEF = 8'h03;
    localparam int unsigned TIMEOUT_DEF   = 15;

    localparam int unsigned STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_RESP   = 2'd2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin selector; grant is combinational, pointer updates on accepted grants.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // r_ptr names the master that wins the next contention
    logic r_ptr;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = r_ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (update && (|req)) begin
            r_ptr <= grant[0];
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master to two-slave bus arbiter with address decode, timeout and registered responses.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned       BUS_WIDTH = BUS_WIDTH_DEF,
    parameter logic [ADDR_W-1:0] S1_ADDR   = S1_ADDR_DEF,
    parameter logic [ADDR_W-1:0] S2_ADDR   = S2_ADDR_DEF,
    parameter int unsigned       TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [ADDR_W-1:0]    m0_addr,
    input  logic [BUS_WIDTH-1:0] m0_wdata,
    output logic                 m0_ack,
    output logic                 m0_err,
    output logic [BUS_WIDTH-1:0] m0_rdata,
    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [ADDR_W-1:0]    m1_addr,
    input  logic [BUS_WIDTH-1:0] m1_wdata,
    output logic                 m1_ack,
    output logic                 m1_err,
    output logic [BUS_WIDTH-1:0] m1_rdata,
    output logic                 s1_wb,
    output logic                 s1_rb,
    output logic [ADDR_W-1:0]    s1_addr,
    output logic [BUS_WIDTH-1:0] s1_wdata,
    input  logic [BUS_WIDTH-1:0] s1_rdata,
    input  logic                 s1_ack,
    output logic                 s2_wb,
    output logic                 s2_rb,
    output logic [ADDR_W-1:0]    s2_addr,
    output logic [BUS_WIDTH-1:0] s2_wdata,
    input  logic [BUS_WIDTH-1:0] s2_rdata,
    input  logic                 s2_ack
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t               r_state,   w_state_n;
    logic                 r_gnt,     w_gnt_n;
    logic                 r_we,      w_we_n;
    logic                 r_sel,     w_sel_n;
    logic [CNT_W-1:0]     r_cnt,     w_cnt_n;
    logic [1:0]           r_m_ack,   w_m_ack_n;
    logic [1:0]           r_m_err,   w_m_err_n;
    logic [BUS_WIDTH-1:0] r_m_rdata  [2];
    logic [BUS_WIDTH-1:0] w_m_rdata_n[2];
    logic [1:0]           r_s_wb,    w_s_wb_n;
    logic [1:0]           r_s_rb,    w_s_rb_n;
    logic [ADDR_W-1:0]    r_s_addr   [2];
    logic [ADDR_W-1:0]    w_s_addr_n [2];
    logic [BUS_WIDTH-1:0] r_s_wdata  [2];
    logic [BUS_WIDTH-1:0] w_s_wdata_n[2];

    logic [1:0]           w_grant;
    logic                 w_update;
    logic                 w_sel_we;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [BUS_WIDTH-1:0] w_sel_wdata;
    logic                 w_hit1;
    logic                 w_hit2;
    logic                 w_slv_ack;
    logic [BUS_WIDTH-1:0] w_slv_rdata;
    logic                 w_tmo;

    // Requests only matter while idle, so the pointer moves only on IDLE grants
    assign w_update = (r_state == ST_IDLE);

    rr_arbiter2 u_rr (
        .clock  (clock),
        .reset  (reset),
        .req    ({m1_req, m0_req}),
        .update (w_update),
        .grant  (w_grant)
    );

    assign w_sel_we    = w_grant[1] ? m1_we    : m0_we;
    assign w_sel_addr  = w_grant[1] ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_grant[1] ? m1_wdata : m0_wdata;
    assign w_hit1      = (w_sel_addr == S1_ADDR);
    assign w_hit2      = !w_hit1 && (w_sel_addr == S2_ADDR);
    assign w_slv_ack   = r_sel ? s2_ack   : s1_ack;
    assign w_slv_rdata = r_sel ? s2_rdata : s1_rdata;
    assign w_tmo       = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_state_n   = r_state;
        w_gnt_n     = r_gnt;
        w_we_n      = r_we;
        w_sel_n     = r_sel;
        w_cnt_n     = r_cnt;
        w_m_ack_n   = 2'b00;
        w_m_err_n   = 2'b00;
        w_m_rdata_n = r_m_rdata;
        w_s_wb_n    = r_s_wb;
        w_s_rb_n    = r_s_rb;
        w_s_addr_n  = r_s_addr;
        w_s_wdata_n = r_s_wdata;
        case (r_state)
            ST_IDLE: begin
                if (|w_grant) begin
                    w_gnt_n = w_grant[1];
                    w_we_n  = w_sel_we;
                    if (w_hit1 || w_hit2) begin
                        w_state_n           = ST_ACCESS;
                        w_sel_n             = w_hit2;
                        w_cnt_n             = '0;
                        w_s_wb_n[w_hit2]    = w_sel_we;
                        w_s_rb_n[w_hit2]    = !w_sel_we;
                        w_s_addr_n[w_hit2]  = w_sel_addr;
                        w_s_wdata_n[w_hit2] = w_sel_wdata;
                    end else begin
                        w_state_n               = ST_RESP;
                        w_m_ack_n[w_grant[1]]   = 1'b1;
                        w_m_err_n[w_grant[1]]   = 1'b1;
                        w_m_rdata_n[w_grant[1]] = '0;
                    end
                end
            end
            ST_ACCESS: begin
                // Ack is checked first so it wins over a coincident timeout
                if (w_slv_ack) begin
                    w_state_n       = ST_RESP;
                    w_s_wb_n[r_sel] = 1'b0;
                    w_s_rb_n[r_sel] = 1'b0;
                    w_m_ack_n[r_gnt] = 1'b1;
                    if (!r_we) begin
                        w_m_rdata_n[r_gnt] = w_slv_rdata;
                    end
                end else if (w_tmo) begin
                    w_state_n          = ST_RESP;
                    w_s_wb_n[r_sel]    = 1'b0;
                    w_s_rb_n[r_sel]    = 1'b0;
                    w_m_ack_n[r_gnt]   = 1'b1;
                    w_m_err_n[r_gnt]   = 1'b1;
                    w_m_rdata_n[r_gnt] = '0;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_gnt     <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= 1'b0;
            r_cnt     <= '0;
            r_m_ack   <= 2'b00;
            r_m_err   <= 2'b00;
            r_m_rdata <= '{default: '0};
            r_s_wb    <= 2'b00;
            r_s_rb    <= 2'b00;
            r_s_addr  <= '{default: '0};
            r_s_wdata <= '{default: '0};
        end else begin
            r_state   <= w_state_n;
            r_gnt     <= w_gnt_n;
            r_we      <= w_we_n;
            r_sel     <= w_sel_n;
            r_cnt     <= w_cnt_n;
            r_m_ack   <= w_m_ack_n;
            r_m_err   <= w_m_err_n;
            r_m_rdata <= w_m_rdata_n;
            r_s_wb    <= w_s_wb_n;
            r_s_rb    <= w_s_rb_n;
            r_s_addr  <= w_s_addr_n;
            r_s_wdata <= w_s_wdata_n;
        end
    end

    assign m0_ack   = r_m_ack[0];
    assign m0_err   = r_m_err[0];
    assign m0_rdata = r_m_rdata[0];
    assign m1_ack   = r_m_ack[1];
    assign m1_err   = r_m_err[1];
    assign m1_rdata = r_m_rdata[1];
    assign s1_wb    = r_s_wb[0];
    assign s1_rb    = r_s_rb[0];
    assign s1_addr  = r_s_addr[0];
    assign s1_wdata = r_s_wdata[0];
    assign s2_wb    = r_s_wb[1];
    assign s2_rb    = r_s_rb[1];
    assign s2_addr  = r_s_addr[1];
    assign s2_wdata = r_s_wdata[1];

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: transfers, round-robin, miss, timeout, reset abort.
module tb_bus_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic       m0_ack, m0_err, m1_ack, m1_err;
    logic [7:0] m0_rdata, m1_rdata;
    logic       s1_wb, s1_rb, s2_wb, s2_rb;
    logic [7:0] s1_addr, s1_wdata, s2_addr, s2_wdata;
    logic [7:0] s1_rdata, s2_rdata;
    logic       s1_ack, s2_ack;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clock = ~clock;

    bus_arbiter dut (
        .clock    (clock),
        .reset    (reset),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .m1_rdata (m1_rdata),
        .s1_wb    (s1_wb),
        .s1_rb    (s1_rb),
        .s1_addr  (s1_addr),
        .s1_wdata (s1_wdata),
        .s1_rdata (s1_rdata),
        .s1_ack   (s1_ack),
        .s2_wb    (s2_wb),
        .s2_rb    (s2_rb),
        .s2_addr  (s2_addr),
        .s2_wdata (s2_wdata),
        .s2_rdata (s2_rdata),
        .s2_ack   (s2_ack)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_m0(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    endtask

    task automatic drive_m1(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    endtask

    initial begin
        reset = 1'b1;
        drive_m0(1'b0, 1'b0, 8'h00, 8'h00);
        drive_m1(1'b0, 1'b0, 8'h00, 8'h00);
        s1_rdata = 8'h00; s2_rdata = 8'h00; s1_ack = 1'b0; s2_ack = 1'b0;
        tick();
        tick();
        chk("rst_m0_ack",   32'(m0_ack),   32'h0);
        chk("rst_m1_ack",   32'(m1_ack),   32'h0);
        chk("rst_s1_wb",    32'(s1_wb),    32'h0);
        chk("rst_s1_addr",  32'(s1_addr),  32'h0);
        chk("rst_m0_rdata", 32'(m0_rdata), 32'h0);
        reset = 1'b0;

        // m0 write to slave 1, ack on the second ACCESS edge
        drive_m0(1'b1, 1'b1, 8'h02, 8'hAA);
        tick();
        chk("wr_s1_wb_c1",  32'(s1_wb),    32'h1);
        chk("wr_s1_wdata",  32'(s1_wdata), 32'hAA);
        chk("wr_s1_addr",   32'(s1_addr),  32'h02);
        chk("wr_s1_rb",     32'(s1_rb),    32'h0);
        chk("wr_m0_ack_c1", 32'(m0_ack),   32'h0);
        m0_req = 1'b0;
        tick();
        chk("wr_s1_wb_c2",  32'(s1_wb),    32'h1);
        chk("wr_m0_ack_c2", 32'(m0_ack),   32'h0);
        s1_ack = 1'b1;
        tick();
        chk("wr_s1_wb_drop", 32'(s1_wb),   32'h0);
        chk("wr_m0_ack",     32'(m0_ack),  32'h1);
        chk("wr_m0_err",     32'(m0_err),  32'h0);
        chk("wr_m0_rdata",   32'(m0_rdata), 32'h0);
        chk("wr_s2_strobe",  32'({s2_wb, s2_rb}), 32'h0);
        chk("wr_s2_addr",    32'(s2_addr), 32'h0);
        chk("wr_s2_wdata",   32'(s2_wdata), 32'h0);
        s1_ack = 1'b0;
        tick();
        chk("wr_m0_ack_end", 32'(m0_ack), 32'h0);

        // m1 read from slave 2 with ack already waiting
        drive_m1(1'b1, 1'b0, 8'h03, 8'h00);
        s2_rdata = 8'h5C; s2_ack = 1'b1;
        tick();
        chk("rd_s2_rb",    32'(s2_rb),  32'h1);
        chk("rd_s1_wb",    32'({s1_wb, s1_rb}), 32'h0);
        chk("rd_m1_ack_0", 32'(m1_ack), 32'h0);
        m1_req = 1'b0;
        tick();
        chk("rd_s2_rb_drop", 32'(s2_rb),    32'h0);
        chk("rd_m1_ack",     32'(m1_ack),   32'h1);
        chk("rd_m1_err",     32'(m1_err),   32'h0);
        chk("rd_m1_rdata",   32'(m1_rdata), 32'h5C);
        chk("rd_m0_ack",     32'(m0_ack),   32'h0);
        s2_ack = 1'b0;
        tick();
        chk("rd_m1_ack_end",  32'(m1_ack),   32'h0);
        chk("rd_m1_rdata_hd", 32'(m1_rdata), 32'h5C);

        // both masters request continuously; grants alternate starting with m0
        drive_m0(1'b1, 1'b1, 8'h02, 8'h11);
        drive_m1(1'b1, 1'b1, 8'h03, 8'h22);
        s1_ack = 1'b1; s2_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_s1_wb", 32'(s1_wb), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("rr_s2_wb", 32'(s2_wb), (i % 2 == 0) ? 32'h0 : 32'h1);
            tick();
            chk("rr_m0_ack", 32'(m0_ack), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("rr_m1_ack", 32'(m1_ack), (i % 2 == 0) ? 32'h0 : 32'h1);
            tick();
        end
        drive_m0(1'b0, 1'b0, 8'h00, 8'h00);
        drive_m1(1'b0, 1'b0, 8'h00, 8'h00);
        s1_ack = 1'b0; s2_ack = 1'b0;
        chk("rr_m1_rdata_kept", 32'(m1_rdata), 32'h5C);

        // m0 read from slave 1 to load nonzero rdata
        drive_m0(1'b1, 1'b0, 8'h02, 8'h00);
        s1_rdata = 8'h3C; s1_ack = 1'b1;
        tick();
        chk("rd1_s1_rb", 32'(s1_rb), 32'h1);
        m0_req = 1'b0;
        tick();
        chk("rd1_m0_ack",   32'(m0_ack),   32'h1);
        chk("rd1_m0_rdata", 32'(m0_rdata), 32'h3C);
        s1_ack = 1'b0;
        tick();

        // address miss: no strobe, error response next cycle, rdata cleared
        drive_m0(1'b1, 1'b0, 8'h07, 8'h00);
        tick();
        chk("miss_strobes",  32'({s1_wb, s1_rb, s2_wb, s2_rb}), 32'h0);
        chk("miss_m0_ack",   32'(m0_ack),   32'h1);
        chk("miss_m0_err",   32'(m0_err),   32'h1);
        chk("miss_m0_rdata", 32'(m0_rdata), 32'h0);
        m0_req = 1'b0;
        tick();
        chk("miss_ack_end", 32'(m0_ack), 32'h0);
        chk("miss_err_end", 32'(m0_err), 32'h0);

        // slave 1 never acks: strobe lasts 15 cycles then error
        drive_m0(1'b1, 1'b1, 8'h02, 8'h55);
        tick();
        m0_req = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        chk("tmo_wb_c15",  32'(s1_wb),  32'h1);
        chk("tmo_ack_c15", 32'(m0_ack), 32'h0);
        tick();
        chk("tmo_wb_drop", 32'(s1_wb),    32'h0);
        chk("tmo_m0_ack",  32'(m0_ack),   32'h1);
        chk("tmo_m0_err",  32'(m0_err),   32'h1);
        chk("tmo_rdata",   32'(m0_rdata), 32'h0);
        tick();
        chk("tmo_ack_end", 32'(m0_ack), 32'h0);

        // ack on the 15th ACCESS cycle beats the timeout
        drive_m0(1'b1, 1'b0, 8'h02, 8'h00);
        s1_rdata = 8'h77;
        tick();
        m0_req = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        chk("tack_rb_c15", 32'(s1_rb), 32'h1);
        s1_ack = 1'b1;
        tick();
        chk("tack_rb_drop",  32'(s1_rb),    32'h0);
        chk("tack_m0_ack",   32'(m0_ack),   32'h1);
        chk("tack_m0_err",   32'(m0_err),   32'h0);
        chk("tack_m0_rdata", 32'(m0_rdata), 32'h77);
        s1_ack = 1'b0;
        tick();

        // reset during ACCESS aborts silently and restores m0 priority
        drive_m0(1'b1, 1'b1, 8'h02, 8'h99);
        tick();
        chk("ra_s1_wb", 32'(s1_wb), 32'h1);
        reset = 1'b1;
        tick();
        chk("ra_strobes",  32'({s1_wb, s1_rb, s2_wb, s2_rb}), 32'h0);
        chk("ra_acks",     32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
        chk("ra_s1_addr",  32'(s1_addr),  32'h0);
        chk("ra_s1_wdata", 32'(s1_wdata), 32'h0);
        chk("ra_m0_rdata", 32'(m0_rdata), 32'h0);
        chk("ra_m1_rdata", 32'(m1_rdata), 32'h0);
        reset = 1'b0;
        drive_m0(1'b1, 1'b1, 8'h02, 8'h44);
        drive_m1(1'b1, 1'b1, 8'h03, 8'h66);
        tick();
        chk("ra_gnt_s1_wb", 32'(s1_wb),    32'h1);
        chk("ra_gnt_s2_wb", 32'(s2_wb),    32'h0);
        chk("ra_gnt_wdata", 32'(s1_wdata), 32'h44);
        drive_m0(1'b0, 1'b0, 8'h00, 8'h00);
        drive_m1(1'b0, 1'b0, 8'h00, 8'h00);
        s1_ack = 1'b1;
        tick();
        chk("ra_m0_ack", 32'(m0_ack), 32'h1);
        chk("ra_m1_ack", 32'(m1_ack), 32'h0);
        s1_ack = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
